// File: rtl/pwm_capture.sv
// PWM period / high-time capture: synchronizes pwm_in, measures rise-to-rise
// interval and high duration in clk cycles, and flags a missing edge as a timeout.
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int MAX_CNT = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             level,
    output logic             locked
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MEASURE = 1'b1;

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [0:0]       state;
    logic             s1;
    logic             s2;
    logic             s3;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic             rise;

    assign rise   = s2 & ~s3;
    assign locked = (state == MEASURE);

    // A rise always closes the current measurement, so it takes priority over
    // the timeout check when both happen at cnt == MAX_CNT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            level     <= 1'b0;
        end else begin
            s1      <= pwm_in;
            s2      <= s1;
            s3      <= s2;
            valid   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= MEASURE;
                        cnt   <= ONE;
                        hcnt  <= ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period    <= cnt;
                        high_time <= hcnt;
                        valid     <= 1'b1;
                        cnt       <= ONE;
                        hcnt      <= ONE;
                    end else if (cnt == MAX_V) begin
                        timeout   <= 1'b1;
                        level     <= s2;
                        period    <= '0;
                        high_time <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                        if (s2) begin
                            hcnt <= hcnt + ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pwm_capture;

    localparam int CNT_W   = 16;
    localparam int MAX_CNT = 100;

    logic             clk;
    logic             reset;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;
    logic             level;
    logic             locked;

    int tests_run    = 0;
    int tests_failed = 0;

    pwm_capture #(.CNT_W(CNT_W), .MAX_CNT(MAX_CNT)) dut (
        .clk       (clk),
        .reset     (reset),
        .pwm_in    (pwm_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .level     (level),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: the input is seen two clocks late; measurements are
    // differences between clock-edge timestamps of detected rising edges.
    int   cyc      = 0;
    int   ref_cyc  = 0;
    int   highs    = 0;
    bit   smp1     = 0;
    bit   smp2     = 0;
    bit   lvl_prev = 0;
    bit   armed    = 0;
    bit   started  = 0;
    bit   e_valid  = 0;
    bit   e_timeout = 0;
    bit   e_level  = 0;
    int   e_period = 0;
    int   e_high   = 0;

    always @(posedge clk) begin
        bit lvl;
        bit rise_seen;
        cyc++;
        started = 1;
        if (!reset) begin
            smp1 = 0; smp2 = 0; lvl_prev = 0; armed = 0;
            e_valid = 0; e_timeout = 0; e_level = 0; e_period = 0; e_high = 0;
        end else begin
            lvl       = smp2;
            rise_seen = lvl && !lvl_prev;
            e_valid   = 0;
            e_timeout = 0;
            if (armed && rise_seen) begin
                e_valid  = 1;
                e_period = cyc - ref_cyc;
                e_high   = highs;
                ref_cyc  = cyc;
                highs    = 1;
            end else if (armed && (cyc - ref_cyc == MAX_CNT)) begin
                e_timeout = 1;
                e_level   = lvl;
                e_period  = 0;
                e_high    = 0;
                armed     = 0;
            end else if (!armed && rise_seen) begin
                armed   = 1;
                ref_cyc = cyc;
                highs   = 1;
            end else if (armed && lvl) begin
                highs++;
            end
            lvl_prev = lvl;
            smp2     = smp1;
            smp1     = pwm_in;
        end
    end

    // Monitor of DUT events used by the directed literal checks.
    int neg_cyc        = 0;
    int rep_p[$];
    int rep_h[$];
    int rep_cyc[$];
    int to_count       = 0;
    int to_cyc         = 0;
    int to_level       = 0;
    int to_period      = 0;
    int to_high        = 0;

    always @(negedge clk) begin
        neg_cyc++;
        if (started) begin
            check_output("valid",     32'(valid),     32'(e_valid));
            check_output("timeout",   32'(timeout),   32'(e_timeout));
            check_output("level",     32'(level),     32'(e_level));
            check_output("locked",    32'(locked),    32'(armed));
            check_output("period",    32'(period),    32'(e_period));
            check_output("high_time", 32'(high_time), 32'(e_high));
        end
        if (valid === 1'b1) begin
            rep_p.push_back(int'(period));
            rep_h.push_back(int'(high_time));
            rep_cyc.push_back(neg_cyc);
        end
        if (timeout === 1'b1) begin
            to_count++;
            to_cyc    = neg_cyc;
            to_level  = int'(level);
            to_period = int'(period);
            to_high   = int'(high_time);
        end
    end

    int rep_base = 0;
    int to_base  = 0;

    task automatic drive(input logic val, input int k);
        repeat (k) begin
            pwm_in = val;
            @(negedge clk);
        end
    endtask

    task automatic apply_stimulus(input int p, input int h, input int n);
        repeat (n) begin
            drive(1'b1, h);
            drive(1'b0, p - h);
        end
    endtask

    // Holds reset low for the given cycles, then snapshots the monitor
    // positions while valid/timeout are known to be clear.
    task automatic do_reset(input int cycles, input logic pwm_val);
        pwm_in = pwm_val;
        reset  = 1'b0;
        repeat (cycles) @(negedge clk);
        rep_base = rep_p.size();
        to_base  = to_count;
        reset    = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        pwm_in = 1'b0;
        @(negedge clk);

        do_reset(2, 1'b0);
        check_output("rst_period",    32'(period),    32'd0);
        check_output("rst_high_time", 32'(high_time), 32'd0);
        check_output("rst_valid",     32'(valid),     32'd0);
        check_output("rst_timeout",   32'(timeout),   32'd0);
        check_output("rst_level",     32'(level),     32'd0);
        check_output("rst_locked",    32'(locked),    32'd0);

        // Four periods of 80/40: three reports, still locked.
        drive(1'b0, 3);
        apply_stimulus(80, 40, 4);
        check_output("s1_count",  32'(rep_p.size() - rep_base), 32'd3);
        check_output("s1_period", 32'(rep_p[rep_p.size()-1]),   32'd80);
        check_output("s1_high",   32'(rep_h[rep_h.size()-1]),   32'd40);
        check_output("s1_locked", 32'(locked),                  32'd1);

        // Duty change 10/1 -> 10/9 with no dropped update.
        do_reset(2, 1'b0);
        drive(1'b0, 3);
        apply_stimulus(10, 1, 3);
        apply_stimulus(10, 9, 3);
        drive(1'b1, 1);
        drive(1'b0, 5);
        check_output("s2_count", 32'(rep_p.size() - rep_base), 32'd6);
        check_output("s2_p2",    32'(rep_p[rep_base+2]),        32'd10);
        check_output("s2_h2",    32'(rep_h[rep_base+2]),        32'd1);
        check_output("s2_p3",    32'(rep_p[rep_base+3]),        32'd10);
        check_output("s2_h3",    32'(rep_h[rep_base+3]),        32'd9);
        check_output("s2_h5",    32'(rep_h[rep_base+5]),        32'd9);

        // Input stuck high after a rise: a single timeout 100 cycles later.
        do_reset(2, 1'b0);
        drive(1'b0, 3);
        apply_stimulus(20, 10, 2);
        drive(1'b1, 250);
        check_output("s3_to_count", 32'(to_count - to_base),                  32'd1);
        check_output("s3_to_delay", 32'(to_cyc - rep_cyc[rep_cyc.size()-1]), 32'd100);
        check_output("s3_to_level", 32'(to_level),                            32'd1);
        check_output("s3_to_per",   32'(to_period),                           32'd0);
        check_output("s3_to_high",  32'(to_high),                             32'd0);
        check_output("s3_locked",   32'(locked),                              32'd0);

        // Period exactly MAX_CNT: rise wins over timeout.
        do_reset(2, 1'b0);
        drive(1'b0, 3);
        apply_stimulus(100, 50, 3);
        drive(1'b1, 1);
        drive(1'b0, 5);
        check_output("s4_count",    32'(rep_p.size() - rep_base), 32'd3);
        check_output("s4_period",   32'(rep_p[rep_base]),         32'd100);
        check_output("s4_high",     32'(rep_h[rep_base+2]),       32'd50);
        check_output("s4_to_count", 32'(to_count - to_base),      32'd0);

        // One-cycle reset in the low phase of a running 20/10 stream.
        do_reset(2, 1'b0);
        drive(1'b0, 3);
        apply_stimulus(20, 10, 3);
        drive(1'b1, 10);
        drive(1'b0, 5);
        do_reset(1, 1'b0);
        check_output("s5_rst_period", 32'(period),    32'd0);
        check_output("s5_rst_high",   32'(high_time), 32'd0);
        check_output("s5_rst_locked", 32'(locked),    32'd0);
        drive(1'b0, 4);
        apply_stimulus(20, 10, 3);
        drive(1'b1, 1);
        drive(1'b0, 5);
        check_output("s5_count",  32'(rep_p.size() - rep_base), 32'd3);
        check_output("s5_period", 32'(rep_p[rep_base]),         32'd20);
        check_output("s5_high",   32'(rep_h[rep_base]),         32'd10);

        // Input high through reset release arms only; then 8/3 reports.
        do_reset(2, 1'b1);
        drive(1'b1, 3);
        drive(1'b0, 5);
        apply_stimulus(8, 3, 3);
        drive(1'b1, 1);
        drive(1'b0, 5);
        check_output("s6_count",  32'(rep_p.size() - rep_base), 32'd4);
        check_output("s6_period", 32'(rep_p[rep_base]),         32'd8);
        check_output("s6_high",   32'(rep_h[rep_base]),         32'd3);
        check_output("s6_last_h", 32'(rep_h[rep_h.size()-1]),   32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
